// File: rtl/pc_stack_controller_if.sv
// Byte-wide data-memory port shared by the PC stack controller (master) and memory (slave).
// Read data on mem_out follows a mem_re strobe by one clock.
interface pc_stack_controller_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_in;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_out;

    modport master (output mem_addr, output mem_in, output mem_we, output mem_re, input mem_out);
    modport slave  (input mem_addr, input mem_in, input mem_we, input mem_re, output mem_out);
endinterface

// File: rtl/pc_stack_controller.sv
// Call-stack controller: pushes/pops a 16-bit PC as two bytes on a descending stack.
// Define PC_STACK_CHECK_EN to enable overflow/underflow detection with a sticky stack_err.
module pc_stack_controller #(
    parameter logic [15:0] STACK_BASE  = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_req,
    input  logic                         pop_req,
    input  logic [15:0]                  pc,
    pc_stack_controller_if.master        mem,
    output logic [15:0]                  pc_restore,
    output logic                         pc_restore_valid,
    output logic                         busy,
    output logic [15:0]                  sp,
    output logic                         stack_err,
    output logic [2:0]                   dbg_state
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PUSH_LO = 3'd1;
    localparam logic [2:0] PUSH_HI = 3'd2;
    localparam logic [2:0] POP_HI  = 3'd3;
    localparam logic [2:0] POP_LO  = 3'd4;
    localparam logic [2:0] POP_CAP = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

`ifdef PC_STACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic [2:0]  state;
    logic [15:0] pc_q;
    logic [15:0] addr_q;
    logic [7:0]  din_q;
    logic        we_q;
    logic        re_q;
    logic        overflow;
    logic        underflow;

    // Fewer than two free bytes above the limit, or fewer than two bytes held.
    assign overflow  = CHECK_EN && ({1'b0, sp} < ({1'b0, STACK_LIMIT} + 17'd1));
    assign underflow = CHECK_EN && (sp > (STACK_BASE - 16'd2));

    assign mem.mem_addr = addr_q;
    assign mem.mem_in   = din_q;
    assign mem.mem_we   = we_q;
    assign mem.mem_re   = re_q;
    assign dbg_state    = state;

    // Request handshake: push_req/pop_req act as valid, !busy as ready; a request
    // is taken only on a cycle where state is IDLE, otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc_q             <= 16'h0000;
            addr_q           <= 16'h0000;
            din_q            <= 8'h00;
            we_q             <= 1'b0;
            re_q             <= 1'b0;
            sp               <= STACK_BASE;
            pc_restore       <= 16'h0000;
            pc_restore_valid <= 1'b0;
            busy             <= 1'b0;
            stack_err        <= 1'b0;
        end else begin
            pc_restore_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (push_req) begin
                        busy <= 1'b1;
                        if (overflow) begin
                            stack_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            pc_q   <= pc;
                            addr_q <= sp;
                            din_q  <= pc[7:0];
                            we_q   <= 1'b1;
                            state  <= PUSH_LO;
                        end
                    end else if (pop_req) begin
                        busy <= 1'b1;
                        if (underflow) begin
                            stack_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            addr_q <= sp + 16'd1;
                            re_q   <= 1'b1;
                            state  <= POP_HI;
                        end
                    end
                end
                PUSH_LO: begin
                    addr_q <= sp - 16'd1;
                    din_q  <= pc_q[15:8];
                    state  <= PUSH_HI;
                end
                PUSH_HI: begin
                    we_q  <= 1'b0;
                    sp    <= sp - 16'd2;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                POP_HI: begin
                    addr_q <= sp + 16'd2;
                    state  <= POP_LO;
                end
                POP_LO: begin
                    re_q              <= 1'b0;
                    pc_restore[15:8]  <= mem.mem_out;
                    state             <= POP_CAP;
                end
                POP_CAP: begin
                    pc_restore[7:0]  <= mem.mem_out;
                    sp               <= sp + 16'd2;
                    pc_restore_valid <= 1'b1;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    we_q  <= 1'b0;
                    re_q  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_stack_controller.sv
// Directed bench for pc_stack_controller with a byte memory model and write/restore scoreboards.
// Build with +define+PC_STACK_CHECK_EN to also exercise overflow/underflow.
module tb_pc_stack_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_req = 1'b0;
    logic        pop_req = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] pc_restore;
    logic        pc_restore_valid;
    logic        busy;
    logic [15:0] sp;
    logic        stack_err;
    logic [2:0]  dbg_state;

    pc_stack_controller_if mif ();

    pc_stack_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_req         (push_req),
        .pop_req          (pop_req),
        .pc               (pc),
        .mem              (mif),
        .pc_restore       (pc_restore),
        .pc_restore_valid (pc_restore_valid),
        .busy             (busy),
        .sp               (sp),
        .stack_err        (stack_err),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_arr [0:65535];
    always @(posedge clk) begin
        if (mif.mem_we) mem_arr[mif.mem_addr] <= mif.mem_in;
        if (mif.mem_re) mif.mem_out <= mem_arr[mif.mem_addr];
    end

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exp_pc_q[$];
    logic [15:0] stack_m[$];
    logic [15:0] sp_m = 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flag(input string tag, input logic [31:0] obs);
        total++;
        bad++;
        $error("FAIL %s observed=%0h expected=none", tag, obs);
    endtask

    // Bus monitor: every write and every restore pulse is scored against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.mem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) flag("unexpected_write", {8'h00, mif.mem_addr, mif.mem_in});
                else check("mem_write", {8'h00, mif.mem_addr, mif.mem_in}, {8'h00, exp_q.pop_front()});
            end
            if (mif.mem_re) re_cnt++;
            if (mif.mem_we && mif.mem_re) flag("we_re_overlap", 32'h1);
            if (pc_restore_valid) begin
                if (exp_pc_q.size() == 0) flag("unexpected_restore", {16'h0, pc_restore});
                else check("pc_restore", {16'h0, pc_restore}, {16'h0, exp_pc_q.pop_front()});
            end
        end
    end

    task automatic do_push(input logic [15:0] v, input bit with_pop);
        @(negedge clk);
        push_req = 1'b1;
        pop_req  = with_pop;
        pc       = v;
        exp_q.push_back({sp_m, v[7:0]});
        exp_q.push_back({sp_m - 16'd1, v[15:8]});
        stack_m.push_back(v);
        sp_m = sp_m - 16'd2;
        @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
        check("push_busy_t1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("push_busy_t2", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("push_busy_t3", {31'h0, busy}, 32'h0);
        check("push_sp", {16'h0, sp}, {16'h0, sp_m});
    endtask

    task automatic do_pop();
        @(negedge clk);
        pop_req = 1'b1;
        exp_pc_q.push_back(stack_m.pop_back());
        sp_m = sp_m + 16'd2;
        @(negedge clk);
        pop_req = 1'b0;
        check("pop_busy_t1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("pop_busy_t2", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("pop_busy_t3", {31'h0, busy}, 32'h1);
        check("pop_valid_t3", {31'h0, pc_restore_valid}, 32'h0);
        @(negedge clk);
        check("pop_valid_t4", {31'h0, pc_restore_valid}, 32'h1);
        check("pop_sp", {16'h0, sp}, {16'h0, sp_m});
        @(negedge clk);
        check("pop_valid_t5", {31'h0, pc_restore_valid}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sp_m = 16'hFFFF;
        stack_m.delete();
    endtask

`ifdef PC_STACK_CHECK_EN
    task automatic do_err(input bit is_push);
        int we0;
        int re0;
        we0 = we_cnt;
        re0 = re_cnt;
        @(negedge clk);
        push_req = is_push;
        pop_req  = !is_push;
        pc       = 16'hDEAD;
        @(negedge clk);
        push_req = 1'b0;
        pop_req  = 1'b0;
        check("err_busy_t1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("err_busy_t2", {31'h0, busy}, 32'h0);
        check("err_flag", {31'h0, stack_err}, 32'h1);
        check("err_sp", {16'h0, sp}, {16'h0, sp_m});
        check("err_no_write", we_cnt, we0);
        check("err_no_read", re_cnt, re0);
    endtask
`endif

    initial begin
        int re0;
        logic [15:0] rv;
        repeat (3) @(negedge clk);
        check("rst_sp", {16'h0, sp}, 32'hFFFF);
        check("rst_addr", {16'h0, mif.mem_addr}, 32'h0);
        check("rst_in", {24'h0, mif.mem_in}, 32'h0);
        check("rst_we", {31'h0, mif.mem_we}, 32'h0);
        check("rst_re", {31'h0, mif.mem_re}, 32'h0);
        check("rst_pc_restore", {16'h0, pc_restore}, 32'h0);
        check("rst_valid", {31'h0, pc_restore_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, stack_err}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        rst_n = 1'b1;

        do_push(16'h1234, 1'b0);
        check("mem_ffff", {24'h0, mem_arr[16'hFFFF]}, 32'h34);
        check("mem_fffe", {24'h0, mem_arr[16'hFFFE]}, 32'h12);
        do_push(16'hABCD, 1'b0);
        do_pop();
        do_pop();
        check("sp_back_base", {16'h0, sp}, 32'hFFFF);

        re0 = re_cnt;
        do_push(16'h5A5A, 1'b1);
        check("both_req_no_read", re_cnt, re0);
        check("both_req_sp", {16'h0, sp}, 32'hFFFD);
        do_pop();

        for (int i = 0; i < 16; i++) begin
            if (stack_m.size() == 0 || $urandom_range(0, 1) == 1) begin
                rv = 16'($urandom_range(0, 65535));
                do_push(rv, 1'b0);
            end else begin
                do_pop();
            end
        end
        while (stack_m.size() != 0) do_pop();

        @(negedge clk);
        push_req = 1'b1;
        pc = 16'h7E81;
        exp_q.push_back({sp_m, 8'h81});
        exp_q.push_back({sp_m - 16'd1, 8'h7E});
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        check("mid_push_state", {29'h0, dbg_state}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'h0, mif.mem_we}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_sp", {16'h0, sp}, 32'hFFFF);
        check("mid_rst_addr", {16'h0, mif.mem_addr}, 32'h0);
        check("mid_rst_in", {24'h0, mif.mem_in}, 32'h0);
        check("mid_rst_state", {29'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sp_m = 16'hFFFF;
        stack_m.delete();
        @(negedge clk);
        check("post_rst_sp", {16'h0, sp}, 32'hFFFF);
        check("partial_lo_written", {24'h0, mem_arr[16'hFFFF]}, 32'h81);
        do_push(16'hC0DE, 1'b0);
        do_pop();

`ifdef PC_STACK_CHECK_EN
        do_reset();
        do_err(1'b0);
        do_reset();
        for (int i = 0; i < 128; i++) do_push(16'($urandom_range(0, 65535)), 1'b0);
        check("full_sp", {16'h0, sp}, 32'hFEFF);
        check("full_no_err", {31'h0, stack_err}, 32'h0);
        do_err(1'b1);
        do_reset();
        check("err_cleared", {31'h0, stack_err}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        check("write_queue_drained", exp_q.size(), 0);
        check("restore_queue_drained", exp_pc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
